multi_cycle_controller: RTL
===========================

Name: multi_cycle_controller

Overview:
- Moore-style main FSM for the multi-cycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over one shared ALU and one unified memory.
- Drives every datapath select and write enable, including the 3-bit immSrc consumed by the immediate extender.
- Supports lw, sw, R-type, I-ALU, jal, jalr, beq/bne/blt/bge, lui; any other opcode is flagged illegal.

Parameters:
MEM_LAT, 1, memory read latency in cycles (>=1); FETCH and MEMREAD each last exactly MEM_LAT cycles
CNT_W, 4, width of the internal wait counter; must satisfy 2^CNT_W > MEM_LAT

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
op  input  7  instr[6:0] from the instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU result == 0
neg  input  1  ALU result sign bit, from the SUB compare
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  memory write enable
IRWrite  output  1  instruction register and oldPC enable
ResultSrc  output  2  result select: 00=ALUOut, 01=MDR, 10=ALUResult, 11=immExt
ALUSrcA  output  2  ALU A select: 00=PC, 01=oldPC, 10=rs1 register
ALUSrcB  output  2  ALU B select: 00=rs2 register, 01=immExt, 10=constant 4
ALUOp  output  2  00=add, 01=sub, 10=decode from funct3/funct7b5
immSrc  output  3  extender format: 000=I, 001=S, 010=B, 011=J, 100=U
RegWrite  output  1  register file write enable
illegal  output  1  one-cycle pulse in DECODE when op is unsupported

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset: the state register loads FETCH and the wait counter loads 0.
- While rst=1, PCWrite, IRWrite, MemWrite, RegWrite and illegal are forced to 0; all other outputs show their FETCH values.
- Rst asserted mid-instruction aborts it; no write enable fires in that cycle.
- Default output values, unless a state sets them: all enables 0, AdrSrc=0, ResultSrc=00, ALUSrcA=00, ALUSrcB=00, ALUOp=00, immSrc=000.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - The wait counter increments each cycle.
  - IRWrite=1 and PCWrite=1 only when the counter equals MEM_LAT-1; the counter then clears and the FSM goes to DECODE.
  - With MEM_LAT=1, FETCH is one cycle.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch/jal target into ALUOut).
  - immSrc decodes from op: lw/I-ALU/jalr=000, sw=001, branch=010, jal=011, lui=100.
  - Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100111 -> JALR; 1100011 -> BRANCH; 0110111 -> LUI.
  - Any other op: illegal=1 and next state FETCH; no architectural write occurs.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; immSrc is 000 for lw, 001 for sw. Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds MEM_LAT cycles using the wait counter, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then -> FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 for exactly one cycle, then -> FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then -> ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, immSrc=000, then -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00 (ALUOut = target), PCWrite=1, then -> ALUWB.
  - ALUWB then writes oldPC+4 to rd.
- JALR: ALUSrcA=10, ALUSrcB=01, immSrc=000, ALUOp=00, then -> JALR2.
- JALR2: ResultSrc=00, PCWrite=1 (loads rs1+imm), ALUSrcA=01, ALUSrcB=10, then -> ALUWB.
  - In ALUWB, ALUOut holds oldPC+4.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, immSrc=010.
  - PCWrite = taken, where: beq=zero, bne=!zero, blt=neg, bge=!neg.
  - Unsupported funct3 gives taken=0.
  - Next state FETCH in all cases.
- LUI: ResultSrc=11, immSrc=100, RegWrite=1, then -> FETCH.
- Every instruction class returns to FETCH. Latency in cycles with MEM_LAT=L: lw 2L+3, sw L+3, R/I 3+L, branch 2+L, jal L+3, jalr L+4, lui L+2.

Test Plan:
- Reset held 2 cycles, then released -> FETCH; IRWrite=PCWrite=1 on the first post-reset cycle (MEM_LAT=1); no enable is high during reset.
- lw (op=0000011), MEM_LAT=3 -> IRWrite pulses once in the 3rd FETCH cycle; AdrSrc=1 for 3 MEMREAD cycles; RegWrite=1 with ResultSrc=01 on cycle 9 exactly.
- beq with zero=1, then beq with zero=0 -> PCWrite=1 and 0 respectively in BRANCH; immSrc=010 and ALUOp=01 in both.
- bge (funct3=101) with neg=1 -> PCWrite=0; blt (funct3=100) with neg=1 -> PCWrite=1.
- jal -> immSrc=011 in DECODE; PCWrite=1 in JAL; RegWrite=1 next cycle; 4 cycles total.
- op=1111111 -> illegal=1 for one cycle, next state FETCH, no RegWrite/MemWrite; rst asserted during MEMWRITE -> MemWrite=0 that cycle, FSM in FETCH afterwards.

Source files
------------

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: Moore main FSM sequencing the multi-cycle RV32I datapath.
module multi_cycle_controller #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       neg,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] immSrc,
  output logic       RegWrite,
  output logic       illegal
);
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, JAL, JALR, JALR2, BRANCH, LUI
  } state_t;

  state_t state, nxt, st;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic pc_w, mem_w, ir_w, reg_w, ill, taken, last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
    end
  end

  // Under reset the outputs reflect FETCH regardless of the stored state.
  assign st = rst ? FETCH : state;
  assign last = cnt == LAST;
  assign taken = funct3 == 3'b000 ? zero :
                 funct3 == 3'b001 ? !zero :
                 funct3 == 3'b100 ? neg :
                 funct3 == 3'b101 ? !neg : 1'b0;

  always_comb begin
    nxt = st;
    cnt_nxt = '0;
    pc_w = 1'b0;
    mem_w = 1'b0;
    ir_w = 1'b0;
    reg_w = 1'b0;
    ill = 1'b0;
    AdrSrc = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b00;
    ALUOp = 2'b00;
    immSrc = 3'b000;
    case (st)
      FETCH: begin
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        cnt_nxt = last ? '0 : cnt + 1'b1;
        ir_w = last;
        pc_w = last;
        nxt = last ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        immSrc = op == OP_SW ? 3'b001 :
                 op == OP_BR ? 3'b010 :
                 op == OP_JAL ? 3'b011 :
                 op == OP_LUI ? 3'b100 : 3'b000;
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R: nxt = EXECR;
          OP_I: nxt = EXECI;
          OP_JAL: nxt = JAL;
          OP_JALR: nxt = JALR;
          OP_BR: nxt = BRANCH;
          OP_LUI: nxt = LUI;
          default: begin
            ill = 1'b1;
            nxt = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        immSrc = op == OP_SW ? 3'b001 : 3'b000;
        nxt = op == OP_SW ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        cnt_nxt = last ? '0 : cnt + 1'b1;
        nxt = last ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w = 1'b1;
        nxt = FETCH;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w = 1'b1;
        nxt = FETCH;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp = 2'b10;
        nxt = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp = 2'b10;
        nxt = ALUWB;
      end
      ALUWB: begin
        reg_w = 1'b1;
        nxt = FETCH;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_w = 1'b1;
        nxt = ALUWB;
      end
      JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        nxt = JALR2;
      end
      JALR2: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_w = 1'b1;
        nxt = ALUWB;
      end
      BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp = 2'b01;
        immSrc = 3'b010;
        pc_w = taken;
        nxt = FETCH;
      end
      LUI: begin
        ResultSrc = 2'b11;
        immSrc = 3'b100;
        reg_w = 1'b1;
        nxt = FETCH;
      end
      default: nxt = FETCH;
    endcase
  end

  assign PCWrite = pc_w & ~rst;
  assign MemWrite = mem_w & ~rst;
  assign IRWrite = ir_w & ~rst;
  assign RegWrite = reg_w & ~rst;
  assign illegal = ill & ~rst;

  logic unused;
  assign unused = funct7b5;
endmodule
